// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared definitions for the GPIO bus arbiter: bus widths, access directions, register map, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_bus_arbiter_pkg;

    // GPIO slave bus geometry
    localparam int GPIO_ADDR_W = 2;
    localparam int WORD_DATA_W = 32;

    // Bus direction encoding on rw
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // GPIO slave register map
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IN_DATA    = 2'h0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OUT_DATA   = 2'h1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_INOUT_DATA = 2'h2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_INOUT_IO   = 2'h3;

    // Arbiter defaults
    localparam int GPIO_ARB_NUM_M   = 4;
    localparam int GPIO_ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/gpio_arb_rr.sv
// Round-robin picker: first requester at or after rr_ptr, searching circularly.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module gpio_arb_rr
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int NUM_M = GPIO_ARB_NUM_M,
    localparam int IW = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    // One extra bit so rr_ptr + i cannot overflow before the modulo wrap
    typedef logic [IW:0] wide_idx_t;
    wide_idx_t idx;

    // Walk the masters starting at rr_ptr; the first set request wins
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_M; i++) begin
            idx = wide_idx_t'(rr_ptr) + wide_idx_t'(i);
            if (idx >= wide_idx_t'(NUM_M)) begin
                idx = idx - wide_idx_t'(NUM_M);
            end
            if (!valid && req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin ownership arbiter sharing one GPIO slave port among NUM_M masters; optional watchdog via GPIO_ARB_TIMEOUT_EN.
// Latency: grant one edge after request; strobes and completions pass through combinationally (zero added cycles).
// Backpressure: at most one slave access outstanding; a new strobe is held off until the slave (or watchdog) completes the previous one.
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int NUM_M   = GPIO_ARB_NUM_M,
    parameter int AW      = GPIO_ADDR_W,
    parameter int DW      = WORD_DATA_W,
    parameter int TIMEOUT = GPIO_ARB_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_M-1:0]    m_req,
    output logic [NUM_M-1:0]    m_grant,
    input  logic [NUM_M-1:0]    m_as_,
    input  logic [NUM_M-1:0]    m_rw,
    input  logic [NUM_M*AW-1:0] m_addr,
    input  logic [NUM_M*DW-1:0] m_wr_data,
    output logic [DW-1:0]       m_rd_data,
    output logic [NUM_M-1:0]    m_rdy_,
    output logic                m_err,
    output logic                s_cs_,
    output logic                s_as_,
    output logic                s_rw,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wr_data,
    input  logic [DW-1:0]       s_rd_data,
    input  logic                s_rdy_
);

    localparam int IW = $clog2(NUM_M);
    typedef logic [IW-1:0] idx_t;

    arb_state_e       state_q, state_d;
    idx_t             owner_q, owner_d;
    idx_t             rr_ptr_q, rr_ptr_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic             outstanding_q, outstanding_d;

    logic             pick_vld;
    idx_t             pick_idx;
    logic             own_as_;
    logic             own_rw;
    logic [AW-1:0]    own_addr;
    logic [DW-1:0]    own_wr_data;
    logic             rdy_eff;
    logic             wdog_fire;
    logic             done;
    logic             issue_ok;
    logic             fwd_as;
    idx_t             owner_next;

    gpio_arb_rr #(
        .NUM_M (NUM_M)
    ) u_rr (
        .req    (m_req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_vld),
        .winner (pick_idx)
    );

    // Owner's bus fields
    assign own_as_     = m_as_[owner_q];
    assign own_rw      = m_rw[owner_q];
    assign own_addr    = m_addr[owner_q*AW +: AW];
    assign own_wr_data = m_wr_data[owner_q*DW +: DW];

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Acks that arrive with nothing outstanding belong to an access the watchdog already closed
    assign rdy_eff   = s_rdy_ | ~outstanding_q;
    assign wdog_fire = outstanding_q & s_rdy_ & (cnt_q == CW'(TIMEOUT - 1));

    // Age of the outstanding access; restarts whenever it completes or nothing is pending
    always_comb begin
        cnt_d = '0;
        if (outstanding_q && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign rdy_eff   = s_rdy_;
    assign wdog_fire = 1'b0;
`endif

    // Completion of the outstanding access; a new strobe may go out in the same cycle
    assign done     = outstanding_q & (~rdy_eff | wdog_fire);
    assign issue_ok = ~outstanding_q | done;
    assign fwd_as   = (state_q == ARB_OWN) & ~own_as_ & issue_ok;

    assign owner_next = (owner_q == idx_t'(NUM_M - 1)) ? '0 : owner_q + 1'b1;

    // Outstanding flag: set by a forwarded strobe, cleared by its completion
    always_comb begin
        outstanding_d = outstanding_q;
        if (fwd_as) begin
            outstanding_d = 1'b1;
        end else if (done) begin
            outstanding_d = 1'b0;
        end
    end

    // Ownership FSM: grant, hold while requested, drain a pending access on release
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (!m_req[owner_q]) begin
                    if (outstanding_d) begin
                        state_d = ARB_DRAIN;
                    end else begin
                        state_d  = ARB_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = owner_next;
                    end
                end
            end
            ARB_DRAIN: begin
                if (!outstanding_d) begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Slave-side and master-side outputs
    always_comb begin
        s_cs_     = ~fwd_as;
        s_as_     = ~fwd_as;
        s_rw      = READ;
        s_addr    = '0;
        s_wr_data = '0;
        if (state_q == ARB_OWN) begin
            s_rw      = own_rw;
            s_addr    = own_addr;
            s_wr_data = own_wr_data;
        end
        m_rdy_ = '1;
        if (state_q != ARB_IDLE) begin
            m_rdy_[owner_q] = rdy_eff & ~wdog_fire;
        end
        m_rd_data = wdog_fire ? '0 : s_rd_data;
        m_err     = wdog_fire;
        m_grant   = grant_q;
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule
